// File: rtl/reg_shift_sequencer.sv
// reg_shift_sequencer
//   Multi-cycle controller for register-specified shifts (LSL/LSR/ASR/ROR by
//   Rs[7:0]). It sits in EXE beside the single-cycle immediate Val2 path. Each
//   SHIFT cycle moves the operand by at most STEP bit positions. Carry-out
//   follows the ARM shifter rules.
//
// Parameters
//   STEP        maximum bit positions shifted per cycle (1..32)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   start       request, sampled only in IDLE or DONE
//   flush       synchronous abort, wins over start
//   rm          operand to shift
//   rs_amount   shift amount, Rs[7:0]
//   shift_type  00 LSL, 01 LSR, 10 ASR, 11 ROR
//   carry_in    current CPSR C flag
//   busy        high while in SHIFT (drives hazard/stall logic)
//   done        one-cycle pulse, val_2/carry_out valid
//   val_2       shifted result, held until the next completion
//   carry_out   shifter carry-out, held with val_2

// Bounded one-step shifter. amount is 1..32 whenever the result is used.
// Each type is formed from a 64-bit window. The bit just past the kept 32 bits
// is the last bit shifted out. A later step therefore reports carry 0 once
// LSL/LSR has cleared the word, which gives the count-33 behaviour.
module reg_shift_step (
  input  logic [31:0] data,
  input  logic [5:0]  amount,
  input  logic [1:0]  kind,
  output logic [31:0] result,
  output logic        carry
);
  logic        [63:0] lsl_w;
  logic        [63:0] lsr_w;
  logic signed [63:0] asr_src;
  logic signed [63:0] asr_w;
  logic        [63:0] ror_w;

  always_comb begin
    lsl_w   = {32'b0, data} << amount;
    lsr_w   = {data, 32'b0} >> amount;
    asr_src = {data, 32'b0};
    asr_w   = asr_src >>> amount;
    ror_w   = {data, data} >> amount;
    result  = 32'b0;
    carry   = 1'b0;
    case (kind)
      2'b00: begin result = lsl_w[31:0];  carry = lsl_w[32]; end
      2'b01: begin result = lsr_w[63:32]; carry = lsr_w[31]; end
      2'b10: begin result = asr_w[63:32]; carry = asr_w[31]; end
      default: begin result = ror_w[31:0]; carry = ror_w[31]; end
    endcase
  end
endmodule

module reg_shift_sequencer #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] rm,
  input  logic [7:0]  rs_amount,
  input  logic [1:0]  shift_type,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] val_2,
  output logic        carry_out
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  localparam logic [5:0] STEP_W = 6'(STEP);

  logic [1:0]  state;
  logic [31:0] work;       // partially shifted operand
  logic [5:0]  remaining;  // positions still to shift, at most 33
  logic [1:0]  kind;       // captured shift_type

  // Accept decode
  logic       accept;
  logic [5:0] acc_count;
  logic       acc_carry;   // carry_out for the zero-count early completion

  assign accept = start && !flush && (state == S_IDLE || state == S_DONE);

  always_comb begin
    acc_count = 6'd0;
    case (shift_type)
      T_LSL, T_LSR: acc_count = (rs_amount > 8'd33) ? 6'd33 : rs_amount[5:0];
      T_ASR:        acc_count = (rs_amount > 8'd32) ? 6'd32 : rs_amount[5:0];
      default:      acc_count = {1'b0, rs_amount[4:0]};
    endcase
  end

  // Only ROR reaches a zero count with Rs nonzero (Rs a multiple of 32).
  // That is ROR #32: the value is unchanged and carry is rm[31].
  assign acc_carry = (shift_type == T_ROR && rs_amount != 8'd0) ? rm[31] : carry_in;

  // Per-cycle step
  logic [5:0]  step_n;
  logic        step_last;
  logic [31:0] step_res;
  logic        step_c;

  assign step_n    = (remaining < STEP_W) ? remaining : STEP_W;
  assign step_last = (remaining <= STEP_W);

  reg_shift_step u_step (
    .data   (work),
    .amount (step_n),
    .kind   (kind),
    .result (step_res),
    .carry  (step_c)
  );

  // Sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      work      <= 32'b0;
      remaining <= 6'd0;
      kind      <= T_LSL;
      val_2     <= 32'b0;
      carry_out <= 1'b0;
    end else if (flush) begin
      // Abort: no completion, so the previous result stays visible.
      state     <= S_IDLE;
      remaining <= 6'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            kind <= shift_type;
            if (acc_count == 6'd0) begin
              val_2     <= rm;
              carry_out <= acc_carry;
              state     <= S_DONE;
            end else begin
              work      <= rm;
              remaining <= acc_count;
              state     <= S_SHIFT;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          // start is ignored here. The requester holds it until done.
          work      <= step_res;
          remaining <= remaining - step_n;
          if (step_last) begin
            val_2     <= step_res;
            carry_out <= step_c;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule
